// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the serial add/subtract unit.
//               Holds the FSM state encoding and a ceiling-log2 helper.
//               The helper sizes the chunk counter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // FSM state encoding
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder cell from the combinational library.
// Ports       : a, b, cin  - addend bits and carry in
//               sum, cout  - sum bit and carry out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder_chunk.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_chunk
// Description : Purely combinational ripple chain of BITS_PER_CYCLE
//               full_adder cells. It adds one chunk per clock of the
//               serial adder.
// Ports       : a, b     - chunk operands (b is already inverted for subtract)
//               cin      - carry into the chunk LSB
//               sum      - chunk sum
//               cout     - carry out of the chunk MSB
//               msb_cin  - carry into the chunk MSB cell (for overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_chunk #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] a,
    input  logic [BITS_PER_CYCLE-1:0] b,
    input  logic                      cin,
    output logic [BITS_PER_CYCLE-1:0] sum,
    output logic                      cout,
    output logic                      msb_cin
);

    logic [BITS_PER_CYCLE:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .sum  (sum[i]),
            .cout (w_carry[i+1])
        );
    end

    assign cout    = w_carry[BITS_PER_CYCLE];
    assign msb_cin = w_carry[BITS_PER_CYCLE-1];

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle add/subtract unit. It adds BITS_PER_CYCLE bits
//               per clock, starting with the LSB chunk, and keeps the carry
//               between chunks. It uses a START/READY/DONE handshake.
// Ports       : clk, reset_n       - clock, synchronous active-low reset
//               start              - request, accepted while ready=1
//               a, b, carry_in, sub- operands, captured on accept
//               ready, busy, done  - handshake status (done is a 1-cycle pulse)
//               sum, carry_out,
//               overflow           - registered result, held until next accept
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int c_num_chunks = WIDTH / BITS_PER_CYCLE;
    localparam int c_count_w    = (c_num_chunks > 1) ? clog2(c_num_chunks) : 1;
    localparam logic [c_count_w-1:0] c_last_count = c_count_w'(c_num_chunks - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("serial_adder: WIDTH must be at least 2");
    end
    if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bpc_check
        $error("serial_adder: BITS_PER_CYCLE must divide WIDTH exactly");
    end

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [WIDTH-1:0]          r_a;
    logic [WIDTH-1:0]          r_bx;
    logic                      r_carry;
    logic [c_count_w-1:0]      r_count;
    logic [WIDTH-1:0]          r_sum;
    logic                      r_carry_out;
    logic                      r_overflow;

    logic                      w_accept;
    logic                      w_last;
    logic [BITS_PER_CYCLE-1:0] w_chunk_sum;
    logic                      w_chunk_cout;
    logic                      w_msb_cin;

    assign w_accept = start && ((r_state == c_idle) || (r_state == c_done));
    assign w_last   = (r_count == c_last_count);

    // The operand registers shift right each RUN cycle, so the active
    // chunk is always in the low bits.
    serial_adder_chunk #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_chunk (
        .a       (r_a[BITS_PER_CYCLE-1:0]),
        .b       (r_bx[BITS_PER_CYCLE-1:0]),
        .cin     (r_carry),
        .sum     (w_chunk_sum),
        .cout    (w_chunk_cout),
        .msb_cin (w_msb_cin)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (start) w_next_state = c_run;
            c_run:   if (w_last) w_next_state = c_done;
            c_done:  w_next_state = start ? c_run : c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from the state register only
    // ------------------------------------------------------------------
    always_comb begin
        ready = (r_state == c_idle) || (r_state == c_done);
        busy  = (r_state == c_run);
        done  = (r_state == c_done);
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, chunk accumulation, result flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a         <= '0;
            r_bx        <= '0;
            r_carry     <= 1'b0;
            r_count     <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a         <= a;
            // Subtract is A + ~B + 1: invert B and force the carry in.
            r_bx        <= b ^ {WIDTH{sub}};
            r_carry     <= sub | carry_in;
            r_count     <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (r_state == c_run) begin
            r_sum[r_count*BITS_PER_CYCLE +: BITS_PER_CYCLE] <= w_chunk_sum;
            r_carry <= w_chunk_cout;
            r_a     <= r_a >> BITS_PER_CYCLE;
            r_bx    <= r_bx >> BITS_PER_CYCLE;
            r_count <= r_count + c_count_w'(1);
            if (w_last) begin
                r_carry_out <= w_chunk_cout;
                r_overflow  <= w_chunk_cout ^ w_msb_cin;
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. It has an 8-bit/1-bit
//               instance and a 16-bit/4-bit instance, both checked against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic       s8_start, s8_cin, s8_sub;
    logic [7:0] s8_a, s8_b;
    logic       s8_ready, s8_busy, s8_done, s8_co, s8_ov;
    logic [7:0] s8_sum;

    logic        s16_start, s16_cin, s16_sub;
    logic [15:0] s16_a, s16_b;
    logic        s16_ready, s16_busy, s16_done, s16_co, s16_ov;
    logic [15:0] s16_sum;

    int checks   = 0;
    int failures = 0;

    logic [15:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(s8_start), .a(s8_a), .b(s8_b),
        .carry_in(s8_cin), .sub(s8_sub), .ready(s8_ready), .busy(s8_busy),
        .done(s8_done), .sum(s8_sum), .carry_out(s8_co), .overflow(s8_ov)
    );

    serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(s16_start), .a(s16_a), .b(s16_b),
        .carry_in(s16_cin), .sub(s16_sub), .ready(s16_ready), .busy(s16_busy),
        .done(s16_done), .sum(s16_sum), .carry_out(s16_co), .overflow(s16_ov)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
    // Returns {overflow, carry_out, sum[15:0]}.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        longint ua, ub, sa, sb, total, sres, modv, half;
        logic co, ov;
        logic [15:0] s;
        modv = longint'(1) << w;
        half = modv >> 1;
        ua = longint'(a) & (modv - 1);
        ub = longint'(b) & (modv - 1);
        sa = (ua >= half) ? ua - modv : ua;
        sb = (ub >= half) ? ub - modv : ub;
        if (sub) begin
            total = ua - ub;
            co    = (ua >= ub);
            sres  = sa - sb;
        end else begin
            total = ua + ub + longint'(cin);
            co    = (total >= modv);
            sres  = sa + sb + longint'(cin);
        end
        s  = 16'(total & (modv - 1));
        ov = (sres >= half) || (sres < -half);
        return {ov, co, s};
    endfunction

    function automatic logic get_done(input bit wide);
        return wide ? s16_done : s8_done;
    endfunction
    function automatic logic get_busy(input bit wide);
        return wide ? s16_busy : s8_busy;
    endfunction
    function automatic logic get_ready(input bit wide);
        return wide ? s16_ready : s8_ready;
    endfunction
    function automatic logic [15:0] get_sum(input bit wide);
        return wide ? s16_sum : {8'h00, s8_sum};
    endfunction
    function automatic logic [1:0] get_flags(input bit wide);
        return wide ? {s16_ov, s16_co} : {s8_ov, s8_co};
    endfunction

    task automatic drive(input bit wide, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        if (wide) begin
            s16_start = st; s16_a = a; s16_b = b; s16_cin = cin; s16_sub = sub;
        end else begin
            s8_start = st; s8_a = a[7:0]; s8_b = b[7:0]; s8_cin = cin; s8_sub = sub;
        end
    endtask

    task automatic drive_noise(input bit wide, input logic st);
        drive(wide, st, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Issue one operation (DUT must be ready) and check latency and results.
    // Operands are scrambled right after acceptance; "disturb" also pulses
    // start in RUN cycle 3.
    task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input bit disturb, input string tag);
        int n, w, lat;
        logic [17:0] exp;
        w   = wide ? 16 : 8;
        n   = wide ? 4 : 8;
        exp = model(w, a, b, cin, sub);
        drive(wide, 1'b1, a, b, cin, sub);
        @(posedge clk); #1;
        drive_noise(wide, 1'b0);
        check({tag, "_busy"}, 32'(get_busy(wide)), 32'd1);
        check({tag, "_sum_cleared"}, 32'(get_sum(wide)), 32'd0);
        lat = 0;
        while (get_done(wide) !== 1'b1 && lat < n + 4) begin
            if (disturb && lat == 3) drive_noise(wide, 1'b1);
            else if (disturb && lat == 4) drive_noise(wide, 1'b0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(n));
        check({tag, "_sum"}, 32'(get_sum(wide)), 32'(exp[15:0]));
        check({tag, "_co_ov"}, 32'(get_flags(wide)), 32'(exp[17:16]));
    endtask

    initial begin
        int seen;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(get_ready(d[0])), 32'd1);
            check("rst_busy",  32'(get_busy(d[0])),  32'd0);
            check("rst_done",  32'(get_done(d[0])),  32'd0);
            check("rst_sum",   32'(get_sum(d[0])),   32'd0);
            check("rst_co_ov", 32'(get_flags(d[0])), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed 8-bit cases, issued back-to-back from the DONE cycle.
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_ff_01");
        run_op(1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0, "add_7f_01");
        run_op(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, "sub_05_07");
        run_op(1'b0, 16'h0080, 16'h0001, 1'b1, 1'b1, 1'b0, "sub_80_01");

        // DONE is a single-cycle pulse and the result holds in IDLE.
        repeat (2) begin
            @(posedge clk); #1;
            check("hold_done",  32'(s8_done),  32'd0);
            check("hold_ready", 32'(s8_ready), 32'd1);
            check("hold_sum",   32'(s8_sum),   32'h7F);
            check("hold_co_ov", 32'({s8_ov, s8_co}), 32'b11);
        end

        // START while busy is ignored and operand changes have no effect.
        run_op(1'b0, 16'h003C, 16'h005A, 1'b1, 1'b0, 1'b1, "disturb_add");
        run_op(1'b0, 16'h0011, 16'h00C4, 1'b0, 1'b1, 1'b1, "disturb_sub");
        @(posedge clk); #1;

        // Reset during RUN aborts with no DONE pulse.
        drive(1'b0, 1'b1, 16'h00F3, 16'h0034, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(s8_busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort_ready", 32'(s8_ready), 32'd1);
        check("abort_busy",  32'(s8_busy),  32'd0);
        check("abort_done",  32'(s8_done),  32'd0);
        check("abort_sum",   32'(s8_sum),   32'd0);
        check("abort_co_ov", 32'({s8_ov, s8_co}), 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s8_done === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // Random 8-bit operations.
        for (int k = 0; k < 40; k++) begin
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rand8");
        end

        // 16-bit corners.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int s = 0; s < 2; s++) begin
                    run_op(1'b1, corners[i], corners[j], 1'($urandom), s[0], 1'b0, "corner16");
                end
            end
        end

        // 16-bit random operations.
        for (int k = 0; k < 1000; k++) begin
            run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rand16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
